// File: rtl/conv_array_sched.sv
// conv_array_sched: layer-level sequencer for the conv_unit array.
// Takes one layer command at a time. It broadcasts the parameter word and clears the
// buffers, streams weights into each unit in turn, and then broadcasts feature words.
// It gates the array pipeline and counts result beats until the layer completes.
`timescale 1ns/1ps
module conv_array_sched #(
  parameter int N_CONV_UNIT = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int B_PARA      = 64,
  parameter int B_WCNT      = 16,
  parameter int B_OCNT      = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [B_PARA-1:0]      cmd_para,
  input  logic [B_WCNT-1:0]      cmd_wei_words,
  input  logic [B_WCNT-1:0]      cmd_ftm_words,
  input  logic [B_OCNT-1:0]      cmd_out_cnt,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic [B_PARA-1:0]      para,
  output logic                   para_we,
  output logic                   fb_clr,
  output logic                   wb_clr,
  output logic [DATA_WIDTH-1:0]  di,
  output logic [N_CONV_UNIT-1:0] fb_we,
  output logic [N_CONV_UNIT-1:0] wb_we,
  input  logic [N_CONV_UNIT-1:0] fb_full,
  input  logic [N_CONV_UNIT-1:0] wb_full,
  input  logic [N_CONV_UNIT-1:0] fb_sufficient,
  input  logic [N_CONV_UNIT-1:0] wb_sufficient,
  input  logic                   acc_o_valid,
  output logic                   pipe_en,
  output logic                   busy,
  output logic                   done
);

  localparam int SEL_W = (N_CONV_UNIT > 1) ? $clog2(N_CONV_UNIT) : 1;
  localparam logic [SEL_W-1:0] LAST_UNIT = SEL_W'(N_CONV_UNIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_CLR,
    S_LD_WEI,
    S_LD_FTM,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [B_PARA-1:0]      para_q;
  logic [B_WCNT-1:0]      wei_words;
  logic [B_WCNT-1:0]      ftm_words;
  logic [B_OCNT-1:0]      out_cnt;
  logic [B_WCNT-1:0]      wcnt;
  logic [B_WCNT-1:0]      fcnt;
  logic [B_OCNT-1:0]      ocnt;
  logic [SEL_W-1:0]       unit_sel;

  logic [DATA_WIDTH-1:0]  di_p1;
  logic [N_CONV_UNIT-1:0] wb_we_p1;
  logic [N_CONV_UNIT-1:0] fb_we_p1;

  logic                   cmd_hs;
  logic                   s_hs;
  logic                   wei_last;
  logic                   ftm_last;
  logic                   unit_last;
  logic                   cnt_phase;
  logic                   ocnt_hit;
  logic                   run_done;
  logic [N_CONV_UNIT-1:0] unit_onehot;

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign cmd_hs      = cmd_valid & cmd_ready;

  // Stream is only accepted while loading; the weight path honours only the selected unit.
  assign s_ready     = (state == S_LD_WEI) ? ~wb_full[unit_sel] :
                       (state == S_LD_FTM) ? ~(|fb_full)        : 1'b0;
  assign s_hs        = s_valid & s_ready;

  assign wei_last    = (wcnt == wei_words - B_WCNT'(1));
  assign ftm_last    = (fcnt == ftm_words - B_WCNT'(1));
  assign unit_last   = (unit_sel == LAST_UNIT);
  assign unit_onehot = N_CONV_UNIT'(1) << unit_sel;

  // Result beats are counted during feature load and run. A beat arriving on the
  // cycle the count is reached still finishes the layer.
  assign cnt_phase   = (state == S_LD_FTM) || (state == S_RUN);
  assign ocnt_hit    = (ocnt == out_cnt);
  assign run_done    = ocnt_hit | (acc_o_valid & ((ocnt + B_OCNT'(1)) == out_cnt));

  assign pipe_en     = cnt_phase & (&fb_sufficient) & (&wb_sufficient);

  assign para        = para_q;
  assign di          = di_p1;
  assign wb_we       = wb_we_p1;
  assign fb_we       = fb_we_p1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the single-cycle control strobes.
  always_comb begin
    state_nxt = state;
    para_we   = 1'b0;
    fb_clr    = 1'b0;
    wb_clr    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_nxt = S_CFG;
      end
      S_CFG: begin
        para_we   = 1'b1;
        state_nxt = S_CLR;
      end
      S_CLR: begin
        fb_clr = 1'b1;
        wb_clr = 1'b1;
        if (wei_words != '0)      state_nxt = S_LD_WEI;
        else if (ftm_words != '0) state_nxt = S_LD_FTM;
        else                      state_nxt = S_RUN;
      end
      S_LD_WEI: begin
        if (s_hs && wei_last && unit_last)
          state_nxt = (ftm_words != '0) ? S_LD_FTM : S_RUN;
      end
      S_LD_FTM: begin
        if (s_hs && ftm_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (run_done) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, per-unit word counters, unit select and result-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      para_q    <= '0;
      wei_words <= '0;
      ftm_words <= '0;
      out_cnt   <= '0;
      wcnt      <= '0;
      fcnt      <= '0;
      ocnt      <= '0;
      unit_sel  <= '0;
    end else begin
      if (cmd_hs) begin
        para_q    <= cmd_para;
        wei_words <= cmd_wei_words;
        ftm_words <= cmd_ftm_words;
        out_cnt   <= cmd_out_cnt;
        wcnt      <= '0;
        fcnt      <= '0;
        ocnt      <= '0;
        unit_sel  <= '0;
      end
      if ((state == S_LD_WEI) && s_hs) begin
        if (wei_last) begin
          wcnt     <= '0;
          unit_sel <= unit_last ? '0 : unit_sel + SEL_W'(1);
        end else begin
          wcnt <= wcnt + B_WCNT'(1);
        end
      end
      if ((state == S_LD_FTM) && s_hs) begin
        fcnt <= ftm_last ? '0 : fcnt + B_WCNT'(1);
      end
      // Once the target is reached, further beats do not push the count past it.
      if (cnt_phase && acc_o_valid && !ocnt_hit) begin
        ocnt <= ocnt + B_OCNT'(1);
      end
    end
  end

  // ---- p0 -> p1: accepted stream word becomes a buffer write one cycle later ----
  always_ff @(posedge clk) begin
    if (rst) begin
      di_p1    <= '0;
      wb_we_p1 <= '0;
      fb_we_p1 <= '0;
    end else begin
      wb_we_p1 <= ((state == S_LD_WEI) && s_hs) ? unit_onehot : '0;
      fb_we_p1 <= ((state == S_LD_FTM) && s_hs) ? '1 : '0;
      if (s_hs) di_p1 <= s_data;
    end
  end

endmodule

// File: tb/tb_conv_array_sched.sv
// Bench for conv_array_sched. Random layer commands and a randomly paced stream are
// applied. Expected buffer writes are derived from the word index of each layer and
// queued in a scoreboard that an independent monitor drains.
`timescale 1ns/1ps
module tb_conv_array_sched;

  localparam int N  = 8;
  localparam int DW = 64;
  localparam int BP = 64;
  localparam int BW = 16;
  localparam int BO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [BP-1:0] cmd_para = '0;
  logic [BW-1:0] cmd_wei_words = '0;
  logic [BW-1:0] cmd_ftm_words = '0;
  logic [BO-1:0] cmd_out_cnt = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [BP-1:0] para;
  logic          para_we;
  logic          fb_clr;
  logic          wb_clr;
  logic [DW-1:0] di;
  logic [N-1:0]  fb_we;
  logic [N-1:0]  wb_we;
  logic [N-1:0]  fb_full = '0;
  logic [N-1:0]  wb_full = '0;
  logic [N-1:0]  fb_sufficient = '1;
  logic [N-1:0]  wb_sufficient = '1;
  logic          acc_o_valid = 1'b0;
  logic          pipe_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  conv_array_sched #(
    .N_CONV_UNIT(N), .DATA_WIDTH(DW), .B_PARA(BP), .B_WCNT(BW), .B_OCNT(BO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_para(cmd_para),
    .cmd_wei_words(cmd_wei_words), .cmd_ftm_words(cmd_ftm_words), .cmd_out_cnt(cmd_out_cnt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .para(para), .para_we(para_we), .fb_clr(fb_clr), .wb_clr(wb_clr),
    .di(di), .fb_we(fb_we), .wb_we(wb_we),
    .fb_full(fb_full), .wb_full(wb_full),
    .fb_sufficient(fb_sufficient), .wb_sufficient(wb_sufficient),
    .acc_o_valid(acc_o_valid), .pipe_en(pipe_en), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [N-1:0]  wb;
    logic [N-1:0]  fb;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] words[$];
  int            errors = 0;
  int            checks = 0;
  logic [BP-1:0] exp_para = '0;
  int            para_cnt = 0;
  int            clr_cnt = 0;
  int            done_cnt = 0;
  int            widx = 0;
  int            nwords = 0;
  bit            strm_on = 1'b0;

  // Output snapshot taken on the falling edge of each bench cycle.
  logic          sm_done, sm_para_we, sm_clr, sm_pe, sm_sr, sm_cr, sm_busy;
  logic [N-1:0]  sm_wb;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: parameter/clear/done strobes and one scoreboard pop per observed buffer write.
  always @(negedge clk) begin
    if (!rst) begin
      if (para_we) begin
        para_cnt++;
        check("para_value", para, exp_para);
      end
      if (fb_clr || wb_clr) begin
        clr_cnt++;
        check("clr_pair", {fb_clr, wb_clr}, 2'b11);
      end
      if (done) done_cnt++;
      if ((wb_we != '0) || (fb_we != '0)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {wb_we, fb_we, di}, 128'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("buf_write", {wb_we, fb_we, di}, {e.wb, e.fb, e.d});
        end
      end
    end
  end

  // One bench cycle: snapshot outputs mid-cycle, then advance the stream after the edge.
  task automatic cycle();
    bit hs;
    @(negedge clk);
    hs         = s_valid && s_ready;
    sm_done    = done;
    sm_para_we = para_we;
    sm_clr     = fb_clr && wb_clr;
    sm_pe      = pipe_en;
    sm_sr      = s_ready;
    sm_cr      = cmd_ready;
    sm_busy    = busy;
    sm_wb      = wb_we;
    @(posedge clk);
    #1;
    if (hs) widx++;
    if (strm_on && (widx < nwords)) begin
      s_valid = ($urandom_range(3) != 0);
      s_data  = words[widx];
    end else begin
      s_valid = 1'b0;
      s_data  = {$urandom, $urandom};
    end
  endtask

  task automatic run_layer(input logic [BP-1:0] p, input int wei, input int ftm, input int outc,
                           input bit stall, input bit pe_test, input bit acc_early, input int abort_at);
    int  sent;
    bit  stalled;
    bit  tmo;
    words.delete();
    nwords = N * wei + ftm;
    for (int i = 0; i < nwords; i++) words.push_back({$urandom, $urandom});
    // Word i goes to unit i/wei while weights remain, then to every feature buffer.
    for (int i = 0; i < nwords; i++) begin
      wr_t e;
      if (i < N * wei) begin
        e.wb = N'(1) << (i / wei);
        e.fb = '0;
      end else begin
        e.wb = '0;
        e.fb = '1;
      end
      e.d = words[i];
      exp_q.push_back(e);
    end
    exp_para = p; para_cnt = 0; clr_cnt = 0; done_cnt = 0; widx = 0; strm_on = 1'b1;

    cmd_valid = 1'b1; cmd_para = p;
    cmd_wei_words = BW'(wei); cmd_ftm_words = BW'(ftm); cmd_out_cnt = BO'(outc);
    acc_o_valid = acc_early;
    cycle();
    check("cmd_ready_idle", sm_cr, 1'b1);
    cmd_valid = 1'b0;
    cycle();
    check("para_we_cfg", sm_para_we, 1'b1);
    acc_o_valid = 1'b0;
    cycle();
    check("clr_cycle", sm_clr, 1'b1);

    tmo = 1'b1; stalled = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (widx >= nwords) begin
        tmo = 1'b0;
        break;
      end
      if ((abort_at > 0) && (widx >= abort_at)) begin
        rst = 1'b1; strm_on = 1'b0; s_valid = 1'b0;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        done_cnt = 0;
        cycle();
        check("abort_cmd_ready", sm_cr, 1'b1);
        check("abort_busy", sm_busy, 1'b0);
        check("abort_wb_we", sm_wb, '0);
        check("abort_done", sm_done, 1'b0);
        repeat (3) cycle();
        check("abort_no_done", done_cnt, 0);
        return;
      end
      if (stall && !stalled && (widx == 2 * wei)) begin
        stalled = 1'b1;
        wb_full = 8'h04;
        for (int j = 0; j < 5; j++) begin
          cycle();
          check("s_ready_stall", sm_sr, 1'b0);
        end
        wb_full = '0;
        cycle();
        check("s_ready_release", sm_sr, 1'b1);
      end else begin
        cycle();
      end
    end
    if (tmo) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d words expected %0d", widx, nwords);
    end

    if (acc_early) begin
      repeat (2) begin
        cycle();
        check("acc_early_ignored", sm_done, 1'b0);
      end
    end
    if (pe_test) begin
      fb_sufficient = 8'hFE;
      cycle();
      check("pipe_en_insufficient", sm_pe, 1'b0);
      fb_sufficient = 8'hFF;
      cycle();
      check("pipe_en_sufficient", sm_pe, 1'b1);
    end
    if (outc == 0) begin
      cycle();
      check("done_in_run", sm_done, 1'b0);
    end
    sent = 0;
    for (int c = 0; (sent < outc) && (c < 3000); c++) begin
      acc_o_valid = ($urandom_range(1) == 1);
      cycle();
      check("pipe_en_run", sm_pe, 1'b1);
      check("done_before_last_beat", sm_done, 1'b0);
      if (acc_o_valid) sent++;
    end
    acc_o_valid = 1'b0;
    cycle();
    check("done_pulse", sm_done, 1'b1);
    check("pipe_en_done", sm_pe, 1'b0);
    cycle();
    check("done_clears", sm_done, 1'b0);
    check("cmd_ready_after", sm_cr, 1'b1);
    strm_on = 1'b0;
    check("para_we_count", para_cnt, 1);
    check("clr_count", clr_cnt, 1);
    check("done_count", done_cnt, 1);
    check("writes_left", exp_q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_cmd_ready", sm_cr, 1'b1);
    check("rst_busy", sm_busy, 1'b0);
    check("rst_s_ready", sm_sr, 1'b0);
    check("rst_done", sm_done, 1'b0);
    check("rst_pipe_en", sm_pe, 1'b0);
    check("rst_wb_we", sm_wb, '0);
    check("rst_fb_we", fb_we, '0);
    check("rst_di", di, '0);
    check("rst_para", para, '0);
    check("rst_para_we", para_we, 1'b0);
    rst = 1'b0;
    cycle();

    run_layer(64'hA5, 3, 4, 2, 1'b1, 1'b1, 1'b0, 0);
    run_layer({$urandom, $urandom}, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    run_layer({$urandom, $urandom}, 0, 0, 1, 1'b0, 1'b0, 1'b1, 0);
    run_layer({$urandom, $urandom}, 3, 4, 2, 1'b0, 1'b0, 1'b0, 5);
    run_layer({$urandom, $urandom}, 2, 3, 1, 1'b0, 1'b0, 1'b0, 0);
    run_layer({$urandom, $urandom}, 2, 0, 3, 1'b0, 1'b1, 1'b0, 0);
    run_layer({$urandom, $urandom}, 0, 3, 0, 1'b0, 1'b0, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      run_layer({$urandom, $urandom}, $urandom_range(3), $urandom_range(5),
                $urandom_range(3), 1'b0, 1'b0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
